// File: rtl/int32_to_float32_pipe_if.sv
// Handshake/bus bundle for the int32 -> binary32 converter.
// The converter connects through the slave modport; the producer/consumer
// side (issue and writeback logic, or a bench) uses the master modport.
interface int32_to_float32_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_signed;
   logic [1:0]  in_rm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_flags;

   modport master (
      output in_valid, in_data, in_signed, in_rm, out_ready,
      input  in_ready, out_valid, out_data, out_flags
   );

   modport slave (
      input  in_valid, in_data, in_signed, in_rm, out_ready,
      output in_ready, out_valid, out_data, out_flags
   );
endinterface

// File: rtl/int32_to_float32_pipe.sv
// Pipelined int32/uint32 -> IEEE-754 binary32 converter.
// Stage 1 takes the magnitude and normalizes it (leading-zero count plus
// left shift); stage 2 rounds per the requested mode and drives the output
// register. BYPASS_S1 != 0 drops the stage-1 register for latency 1.
module int32_to_float32_pipe #(
   parameter int unsigned BYPASS_S1 = 0
) (
   input logic                  clock,
   input logic                  reset,
   int32_to_float32_pipe_if.slave bus
);

   typedef enum logic [1:0] {
      RM_NEAR_EVEN = 2'b00,
      RM_MIN_MAG   = 2'b01,
      RM_MIN       = 2'b10,
      RM_MAX       = 2'b11
   } rm_e;

   // Stage-1 combinational signals (magnitude and normalizer)
   logic        w_in_sign;
   logic [31:0] w_in_mag;
   logic        w_in_zero;
   logic [4:0]  w_in_dist;
   logic [31:0] w_in_norm;

   // Operand presented to the rounding stage
   logic        w_s2_valid;
   logic        w_s2_sign;
   logic        w_s2_zero;
   logic [4:0]  w_s2_dist;
   logic [31:0] w_s2_norm;
   logic [1:0]  w_s2_rm;

   // Rounding results
   logic [23:0] w_sig;
   logic        w_guard;
   logic        w_sticky;
   logic        w_inexact;
   logic        w_inc;
   logic [24:0] w_sig_r;
   logic [7:0]  w_exp;
   logic [22:0] w_frac;
   logic [31:0] w_res;
   logic [4:0]  w_flags;

   logic        w_out_advance;

   logic        r_out_valid;
   logic [31:0] r_out_data;
   logic [4:0]  r_out_flags;

   // Magnitude, leading-zero distance and normalized significand
   always_comb begin
      w_in_sign = bus.in_signed & bus.in_data[31];
      w_in_mag  = w_in_sign ? (32'd0 - bus.in_data) : bus.in_data;
      w_in_zero = (w_in_mag == '0);
      w_in_dist = '0;
      // Highest set bit wins because later iterations overwrite earlier ones
      for (int unsigned i = 0; i < 32; i++) begin
         if (w_in_mag[i]) w_in_dist = 5'(31 - i);
      end
      w_in_norm = w_in_mag << w_in_dist;
   end

   assign w_out_advance = ~r_out_valid | bus.out_ready;

   generate
      if (BYPASS_S1 != 0) begin : g_bypass
         // Normalized operand goes straight to rounding in the input cycle
         always_comb begin
            w_s2_valid = bus.in_valid;
            w_s2_sign  = w_in_sign;
            w_s2_zero  = w_in_zero;
            w_s2_dist  = w_in_dist;
            w_s2_norm  = w_in_norm;
            w_s2_rm    = bus.in_rm;
         end
         assign bus.in_ready = w_out_advance;
      end else begin : g_stage1
         logic        r_s1_valid;
         logic        r_s1_sign;
         logic        r_s1_zero;
         logic [4:0]  r_s1_dist;
         logic [31:0] r_s1_norm;
         logic [1:0]  r_s1_rm;
         logic        w_in_ready;
         logic        w_in_fire;

         assign w_in_ready   = ~r_s1_valid | w_out_advance;
         assign w_in_fire    = bus.in_valid & w_in_ready;
         assign bus.in_ready = w_in_ready;

         // Stage-1 register: fills on input transfer, empties on advance
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_s1_valid <= 1'b0;
               r_s1_sign  <= 1'b0;
               r_s1_zero  <= 1'b0;
               r_s1_dist  <= '0;
               r_s1_norm  <= '0;
               r_s1_rm    <= '0;
            end else begin
               r_s1_valid <= w_in_fire | (r_s1_valid & ~w_out_advance);
               if (w_in_fire) begin
                  r_s1_sign <= w_in_sign;
                  r_s1_zero <= w_in_zero;
                  r_s1_dist <= w_in_dist;
                  r_s1_norm <= w_in_norm;
                  r_s1_rm   <= bus.in_rm;
               end
            end
         end

         // Stage-1 contents feed the rounding stage
         always_comb begin
            w_s2_valid = r_s1_valid;
            w_s2_sign  = r_s1_sign;
            w_s2_zero  = r_s1_zero;
            w_s2_dist  = r_s1_dist;
            w_s2_norm  = r_s1_norm;
            w_s2_rm    = r_s1_rm;
         end
      end
   endgenerate

   // Round the 24-bit significand and assemble the binary32 result
   always_comb begin
      w_sig     = w_s2_norm[31:8];
      w_guard   = w_s2_norm[7];
      w_sticky  = |w_s2_norm[6:0];
      w_inexact = w_guard | w_sticky;
      w_inc     = 1'b0;
      case (rm_e'(w_s2_rm))
         RM_NEAR_EVEN: w_inc = w_guard & (w_sticky | w_sig[0]);
         RM_MIN_MAG:   w_inc = 1'b0;
         RM_MIN:       w_inc = w_s2_sign & w_inexact;
         RM_MAX:       w_inc = ~w_s2_sign & w_inexact;
         default:      w_inc = 1'b0;
      endcase
      w_sig_r = {1'b0, w_sig} + {24'd0, w_inc};
      w_exp   = 8'd158 - {3'd0, w_s2_dist} + {7'd0, w_sig_r[24]};
      w_frac  = w_sig_r[24] ? '0 : w_sig_r[22:0];
      if (w_s2_zero) begin
         w_res   = '0;
         w_flags = '0;
      end else begin
         w_res   = {w_s2_sign, w_exp, w_frac};
         w_flags = {4'd0, w_inexact};
      end
   end

   // Output register: loads on advance, holds while the consumer stalls
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_flags <= '0;
      end else if (w_out_advance) begin
         r_out_valid <= w_s2_valid;
         if (w_s2_valid) begin
            r_out_data  <= w_res;
            r_out_flags <= w_flags;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_flags = r_out_flags;

endmodule

// File: tb/tb_int32_to_float32_pipe.sv
// Self-checking bench for int32_to_float32_pipe: one instance with the
// stage-1 register (sel 0) and one bypassed (sel 1), each on its own bus.
module tb_int32_to_float32_pipe;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   int32_to_float32_pipe_if bus0 ();
   int32_to_float32_pipe_if bus1 ();

   int32_to_float32_pipe #(.BYPASS_S1(0)) u_dut0 (
      .clock(clock), .reset(reset), .bus(bus0.slave));
   int32_to_float32_pipe #(.BYPASS_S1(1)) u_dut1 (
      .clock(clock), .reset(reset), .bus(bus1.slave));

   typedef struct {
      logic [31:0] d;
      logic        s;
      logic [1:0]  rm;
      logic [31:0] r;
      logic [4:0]  f;
   } vec_t;

   vec_t vecs [14] = '{
      '{32'h7FFFFFFF, 1'b1, 2'd0, 32'h4F000000, 5'h01},
      '{32'h7FFFFFFF, 1'b1, 2'd1, 32'h4EFFFFFF, 5'h01},
      '{32'h7FFFFFFF, 1'b1, 2'd3, 32'h4F000000, 5'h01},
      '{32'h7FFFFFFF, 1'b1, 2'd2, 32'h4EFFFFFF, 5'h01},
      '{32'h01000001, 1'b0, 2'd0, 32'h4B800000, 5'h01},
      '{32'h01000003, 1'b0, 2'd0, 32'h4B800002, 5'h01},
      '{32'h80000000, 1'b1, 2'd0, 32'hCF000000, 5'h00},
      '{32'h00000000, 1'b1, 2'd0, 32'h00000000, 5'h00},
      '{32'h00000000, 1'b0, 2'd1, 32'h00000000, 5'h00},
      '{32'h00000000, 1'b1, 2'd2, 32'h00000000, 5'h00},
      '{32'h00000000, 1'b0, 2'd3, 32'h00000000, 5'h00},
      '{32'hFFFFFFFF, 1'b0, 2'd0, 32'h4F800000, 5'h01},
      '{32'h80000001, 1'b1, 2'd2, 32'hCF000000, 5'h01},
      '{32'h80000001, 1'b1, 2'd1, 32'hCEFFFFFF, 5'h01}
   };

   // Reference: exact integer value, rounded to 24 significant bits
   function automatic void ref_conv(input logic [31:0] d, input logic sg,
                                    input logic [1:0] rm,
                                    output logic [31:0] res, output logic [4:0] fl);
      longint          v;
      longint unsigned m, q, rem, half;
      int              e;
      logic            neg, up;
      v   = sg ? longint'($signed(d)) : longint'({32'd0, d});
      neg = (v < 0);
      m   = neg ? 64'(-v) : 64'(v);
      res = '0;
      fl  = '0;
      if (m == 0) return;
      e = 0;
      for (int i = 0; i < 32; i++) if (m >= (64'd1 << i)) e = i;
      if (e <= 23) begin
         q = m << (23 - e); rem = 0; half = 1;
      end else begin
         q    = m >> (e - 23);
         rem  = m - (q << (e - 23));
         half = 64'd1 << (e - 24);
      end
      case (rm)
         2'd0:    up = (rem > half) || (rem == half && q[0]);
         2'd1:    up = 1'b0;
         2'd2:    up = neg && (rem != 0);
         default: up = !neg && (rem != 0);
      endcase
      q = q + 64'(up);
      if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
      res = {neg, 8'(e + 127), q[22:0]};
      fl  = {4'd0, rem != 0};
   endfunction

   task automatic drive(input int sel, input logic v, input logic [31:0] d,
                        input logic s, input logic [1:0] rm, input logic ordy);
      if (sel == 0) begin
         bus0.in_valid = v; bus0.in_data = d; bus0.in_signed = s;
         bus0.in_rm = rm; bus0.out_ready = ordy;
      end else begin
         bus1.in_valid = v; bus1.in_data = d; bus1.in_signed = s;
         bus1.in_rm = rm; bus1.out_ready = ordy;
      end
   endtask

   task automatic sample(input int sel, output logic ir, output logic ov,
                         output logic [31:0] od, output logic [4:0] of);
      if (sel == 0) begin
         ir = bus0.in_ready; ov = bus0.out_valid; od = bus0.out_data; of = bus0.out_flags;
      end else begin
         ir = bus1.in_ready; ov = bus1.out_valid; od = bus1.out_data; of = bus1.out_flags;
      end
   endtask

   // Single operand on an idle pipe; returns the result and cycles to out_valid
   task automatic do_op(input int sel, input logic [31:0] d, input logic s,
                        input logic [1:0] rm, output logic [31:0] res,
                        output logic [4:0] fl, output int lat);
      logic ir, ov; logic [31:0] od; logic [4:0] of; int n;
      @(negedge clock);
      drive(sel, 1'b1, d, s, rm, 1'b1);
      #1 sample(sel, ir, ov, od, of);
      n = 0;
      while (!ir && n < 20) begin
         @(negedge clock); #1 sample(sel, ir, ov, od, of); n++;
      end
      @(negedge clock);
      drive(sel, 1'b0, '0, 1'b0, 2'd0, 1'b1);
      lat = 1;
      #1 sample(sel, ir, ov, od, of);
      while (!ov && lat < 10) begin
         @(negedge clock); #1 sample(sel, ir, ov, od, of); lat++;
      end
      if (!ov) lat = 99;
      res = od;
      fl  = of;
   endtask

   task automatic test_reset();
      logic ir, ov; logic [31:0] od; logic [4:0] of;
      for (int sel = 0; sel < 2; sel++) begin
         sample(sel, ir, ov, od, of);
         checks++;
         if (ov !== 1'b0 || od !== 32'd0 || of !== 5'd0) begin
            errors++;
            $display("FAIL reset_state sel=%0d got v=%b d=%h f=%h exp v=0 d=0 f=0", sel, ov, od, of);
         end
      end
      @(negedge clock); #2 reset = 1'b0;
      #1;
      for (int sel = 0; sel < 2; sel++) begin
         sample(sel, ir, ov, od, of);
         checks++;
         if (ir !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready sel=%0d got %b exp 1", sel, ir);
         end
      end
   endtask

   task automatic test_latency(input int sel);
      logic [31:0] r; logic [4:0] f; int lat, exp_lat;
      exp_lat = (sel == 0) ? 2 : 1;
      do_op(sel, 32'h00000001, 1'b0, 2'd0, r, f, lat);
      checks++;
      if (r !== 32'h3F800000 || f !== 5'd0 || lat != exp_lat) begin
         errors++;
         $display("FAIL latency_one sel=%0d got %h/%h lat %0d exp 3f800000/00 lat %0d", sel, r, f, lat, exp_lat);
      end
      do_op(sel, 32'hFFFFFFFF, 1'b1, 2'd0, r, f, lat);
      checks++;
      if (r !== 32'hBF800000 || f !== 5'd0 || lat != exp_lat) begin
         errors++;
         $display("FAIL latency_minus_one sel=%0d got %h/%h lat %0d exp bf800000/00 lat %0d", sel, r, f, lat, exp_lat);
      end
   endtask

   task automatic test_rounding(input int sel);
      logic [31:0] r; logic [4:0] f; int lat;
      for (int i = 0; i < 14; i++) begin
         do_op(sel, vecs[i].d, vecs[i].s, vecs[i].rm, r, f, lat);
         checks++;
         if (r !== vecs[i].r || f !== vecs[i].f) begin
            errors++;
            $display("FAIL rounding[%0d] sel=%0d in=%h got %h/%h exp %h/%h",
                     i, sel, vecs[i].d, r, f, vecs[i].r, vecs[i].f);
         end
      end
   endtask

   // Streaming with backpressure: fixed 1,0,0 out_ready pattern or random
   task automatic test_backpressure(input int sel, input int n, input bit rnd);
      logic [31:0] q_r[$]; logic [4:0] q_f[$];
      logic ir, ov, v, s, ordy, prev_stall, exp_ir;
      logic [31:0] od, d, prev_d, er; logic [4:0] of, prev_f, ef; logic [1:0] rm;
      int sent, got, cyc, cap;
      sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_f = '0;
      cap = (sel == 0) ? 2 : 1;
      while (got < n && cyc < 5000) begin
         @(negedge clock);
         v    = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         d    = $urandom >> $urandom_range(0, 31);
         s    = 1'($urandom_range(0, 1));
         rm   = 2'($urandom_range(0, 3));
         ordy = rnd ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
         drive(sel, v, d, s, rm, ordy);
         #1 sample(sel, ir, ov, od, of);
         exp_ir = !(q_r.size() == cap && !ordy);
         checks++;
         if (ir !== exp_ir) begin
            errors++;
            $display("FAIL in_ready sel=%0d cyc=%0d got %b exp %b", sel, cyc, ir, exp_ir);
         end
         if (prev_stall) begin
            checks++;
            if (ov !== 1'b1 || od !== prev_d || of !== prev_f) begin
               errors++;
               $display("FAIL stall_hold sel=%0d got v=%b %h/%h exp v=1 %h/%h", sel, ov, od, of, prev_d, prev_f);
            end
         end
         if (ov === 1'b1 && ordy) begin
            checks++;
            if (q_r.size() == 0) begin
               errors++;
               $display("FAIL spurious_out sel=%0d got %h exp none", sel, od);
            end else begin
               er = q_r.pop_front(); ef = q_f.pop_front();
               if (od !== er || of !== ef) begin
                  errors++;
                  $display("FAIL stream_data sel=%0d item %0d got %h/%h exp %h/%h", sel, got, od, of, er, ef);
               end
            end
            got++;
         end
         if (v && ir === 1'b1) begin
            ref_conv(d, s, rm, er, ef);
            q_r.push_back(er); q_f.push_back(ef);
            sent++;
         end
         prev_stall = (ov === 1'b1) && !ordy;
         prev_d = od; prev_f = of;
         cyc++;
      end
      @(negedge clock);
      drive(sel, 1'b0, '0, 1'b0, 2'd0, 1'b1);
      checks++;
      if (got != n || q_r.size() != 0) begin
         errors++;
         $display("FAIL stream_count sel=%0d got %0d left %0d exp %0d left 0", sel, got, q_r.size(), n);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clock); #1 sample(sel, ir, ov, od, of);
         checks++;
         if (ov !== 1'b0) begin
            errors++;
            $display("FAIL stream_extra sel=%0d got out_valid %b exp 0", sel, ov);
         end
      end
   endtask

   task automatic test_reset_midflight(input int sel);
      logic ir, ov; logic [31:0] od, r; logic [4:0] of, f; int lat, exp_lat;
      exp_lat = (sel == 0) ? 2 : 1;
      @(negedge clock); drive(sel, 1'b1, 32'd100, 1'b0, 2'd0, 1'b0);
      @(negedge clock); drive(sel, 1'b1, 32'd200, 1'b0, 2'd0, 1'b0);
      @(negedge clock); drive(sel, 1'b0, '0, 1'b0, 2'd0, 1'b0);
      #2 reset = 1'b1;
      #1 sample(sel, ir, ov, od, of);
      checks++;
      if (ov !== 1'b0 || od !== 32'd0 || of !== 5'd0) begin
         errors++;
         $display("FAIL async_reset sel=%0d got v=%b d=%h f=%h exp v=0 d=0 f=0", sel, ov, od, of);
      end
      @(negedge clock); #3 reset = 1'b0;
      drive(sel, 1'b0, '0, 1'b0, 2'd0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock); #1 sample(sel, ir, ov, od, of);
         checks++;
         if (ov !== 1'b0) begin
            errors++;
            $display("FAIL stale_after_reset sel=%0d got out_valid %b exp 0", sel, ov);
         end
      end
      do_op(sel, 32'd3, 1'b0, 2'd0, r, f, lat);
      checks++;
      if (r !== 32'h40400000 || f !== 5'd0 || lat != exp_lat) begin
         errors++;
         $display("FAIL post_reset_op sel=%0d got %h/%h lat %0d exp 40400000/00 lat %0d", sel, r, f, lat, exp_lat);
      end
   endtask

   initial begin
      drive(0, 1'b0, '0, 1'b0, 2'd0, 1'b1);
      drive(1, 1'b0, '0, 1'b0, 2'd0, 1'b1);
      #1;
      test_reset();
      for (int sel = 0; sel < 2; sel++) begin
         test_latency(sel);
         test_rounding(sel);
         test_backpressure(sel, 8, 1'b0);
         test_backpressure(sel, 300, 1'b1);
         test_reset_midflight(sel);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout got running exp finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/int32_to_float32_pipe.md
Name: int32_to_float32_pipe

Overview:
Pipelined integer-to-single-precision converter that sits directly downstream of the 32-bit leading-zero normalizer. It accepts a 32-bit signed or unsigned integer and takes its magnitude. The normalizer produces a shift distance and a normalized significand, which this block rounds per the selected mode into an IEEE-754 binary32 result with exception flags. Valid/ready handshakes on both sides let it drop into the FPU issue/writeback path with backpressure.

Parameters:
BYPASS_S1, 0, 1 removes the stage-1 register (normalize and round in one cycle, latency 1); 0 gives latency 2.

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all valid state
in_valid  input  1  input operand present
in_ready  output  1  block can accept the operand this cycle
in_data  input  32  integer operand
in_signed  input  1  1 = two's-complement operand, 0 = unsigned
in_rm  input  2  rounding mode: 00 near-even, 01 minMag, 10 min (-inf), 11 max (+inf)
out_valid  output  1  result present
out_ready  input  1  consumer accepts the result this cycle
out_data  output  32  IEEE binary32 result
out_flags  output  5  {invalid, infinite, overflow, underflow, inexact}

Behaviour:
- Reset (async assert): s1_valid=0, out_valid=0, out_data=0, out_flags=0. Datapath registers need no reset value but must read 0 after reset. Reset mid-operation discards in-flight operands; nothing is emitted for them.
- Transfer occurs on a port when valid & ready are both high in the same cycle. out_data and out_flags hold stable while out_valid=1 and out_ready=0.
- Stage 1 (on input transfer):
  - sign = in_signed & in_data[31].
  - mag = sign ? -in_data : in_data, 32 bits. For -2^31, mag = 0x80000000.
  - mag feeds the normalizer, giving dist[4:0] and norm[31:0].
  - Register sign, zero = (mag==0), dist, norm, rm.
- Stage 2 (rounding):
  - sig = norm[31:8], guard = norm[7], sticky = |norm[6:0], inexact = guard|sticky.
  - Increment condition:
    - near-even: guard & (sticky | sig[0]).
    - minMag: never.
    - min: sign & inexact.
    - max: ~sign & inexact.
  - sig_r = sig + inc, 25 bits wide. If sig_r[24] is set, the exponent adds 1 and the fraction is 0.
  - Biased exponent = 158 - dist (+1 on carry). Range is 127..159, so overflow and underflow are impossible.
  - out_data = {sign, exp[7:0], frac[22:0]}.
  - out_flags = {0,0,0,0,inexact}.
  - zero: out_data = 0x00000000 (+0 in every mode), flags = 0.
- Pipeline control (BYPASS_S1=0):
  - out_advance = ~out_valid | out_ready.
  - in_ready = ~s1_valid | out_advance.
  - Stage 1 moves into the output register when s1_valid & out_advance.
  - A full pipeline accepts 1 op/cycle with continuous out_ready=1.
  - in_ready never depends combinationally on in_valid.
- BYPASS_S1=1: normalize and round in the input cycle; in_ready = out_advance; latency 1.
- Simultaneous input transfer and output drain in the same cycle: both take effect, with no bubble and no loss.
- out_ready low for N cycles with the pipeline full: in_ready=0. No operand is lost or duplicated, and order is preserved.

Test Plan:
1. Latency and basic conversion, BYPASS_S1=0, out_ready=1: in_data=1, unsigned, rm=00. out_valid is high 2 cycles later with out_data=0x3F800000, flags=0. Repeat signed in_data=0xFFFFFFFF: result 0xBF800000.
2. Rounding modes on 0x7FFFFFFF, signed:
   - rm=00: 0x4F000000, flags=0x01.
   - rm=01: 0x4EFFFFFF, flags=0x01.
   - rm=11: 0x4F000000.
   - rm=10: 0x4EFFFFFF.
3. Ties, unsigned, rm=00: 0x01000001 gives 0x4B800000 (inexact); 0x01000003 gives 0x4B800002 (inexact). Boundaries: 0x80000000 signed gives 0xCF000000 with flags=0; 0 gives 0x00000000 in all four modes, flags=0.
4. Backpressure: stream 8 operands back-to-back with out_ready toggling 1,0,0,1,... Required: all 8 results emitted exactly once, in order; out_data stable while stalled; in_ready low only when both stages are full and out_ready=0.
5. Reset mid-flight: assert reset asynchronously (between clock edges) with 2 ops in flight. Required: out_valid=0 immediately; after release, no stale results appear, and the next op has normal latency.
6. BYPASS_S1=1 rerun of scenarios 1 and 4: latency 1, same values and ordering.
